// File: rtl/instr_loader_pkg.sv
// Shared constants for the boot-time instruction memory loader.
package instr_loader_pkg;

    localparam int unsigned LANE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LEN_W      = 32;
    localparam int unsigned LANE_CNT_W = 2;
    localparam int unsigned ST_W       = 3;

    localparam logic [ST_W-1:0] ST_LEN   = 3'd0;
    localparam logic [ST_W-1:0] ST_DATA  = 3'd1;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd2;
    localparam logic [ST_W-1:0] ST_CSUM  = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;
    localparam logic [ST_W-1:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words and keeps a running XOR of every byte seen.
module loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [LANE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c,
    output logic [LANE_W-1:0] csum
);

    logic [LANE_CNT_W-1:0] lane_q;
    logic [WORD_W-1:0]     word_q;

    // word_c already contains the byte being accepted, so the 4th byte is usable in the same cycle
    always_comb begin
        word_c = word_q;
        word_c[{lane_q, 3'b000} +: LANE_W] = byte_data;
        word_done_c = byte_valid && (lane_q == LANE_CNT_W'(3));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            word_q <= '0;
            csum   <= '0;
        end else if (clear) begin
            lane_q <= '0;
            word_q <= '0;
            csum   <= '0;
        end else if (byte_valid) begin
            lane_q <= lane_q + LANE_CNT_W'(1);
            word_q <= word_c;
            csum   <= csum ^ byte_data;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, writes instruction words
// sequentially from BASE_ADDR and releases the core reset only after a verified load.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384,
    parameter int unsigned TIMEOUT   = 1_000_000
)
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic        start_i,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    logic [ST_W-1:0]       state_q, state_d;
    logic [LANE_CNT_W-1:0] len_cnt_q, len_cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [31:0]           idx_q, idx_d;
    logic [31:0]           idle_q, idle_d;
    logic [31:0]           waddr_d, wdata_d;
    logic                  rx_ready_d, mem_we_d, core_rst_d, busy_d, done_d, err_d;
    logic                  idle_run;

    logic                  accept_c;
    logic                  pk_clear_c;
    logic                  pk_valid_c;
    logic [WORD_W-1:0]     pk_word_c;
    logic                  pk_done_c;
    logic [LANE_W-1:0]     pk_csum;

    assign accept_c   = rx_valid_i && rx_ready_o;
    assign pk_clear_c = (state_q == ST_LEN);
    assign pk_valid_c = accept_c && (state_q == ST_DATA);

    loader_byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear       (pk_clear_c),
        .byte_valid  (pk_valid_c),
        .byte_data   (rx_data_i),
        .word_c      (pk_word_c),
        .word_done_c (pk_done_c),
        .csum        (pk_csum)
    );

    // Next-state logic; outputs are decoded from the next state and registered below
    always_comb begin
        state_d   = state_q;
        len_cnt_d = len_cnt_q;
        len_d     = len_q;
        idx_d     = idx_q;
        waddr_d   = mem_waddr_o;
        wdata_d   = mem_wdata_o;
        idle_run  = 1'b0;

        case (state_q)
            ST_LEN: begin
                if (accept_c) begin
                    len_d[{len_cnt_q, 3'b000} +: LANE_W] = rx_data_i;
                    len_cnt_d = len_cnt_q + LANE_CNT_W'(1);
                    if (len_cnt_q == LANE_CNT_W'(3)) begin
                        idx_d = '0;
                        if (len_d == '0 || len_d > 32'(MAX_WORDS)) state_d = ST_ERR;
                        else                                      state_d = ST_DATA;
                    end
                end else begin
                    idle_run = (len_cnt_q != '0);
                end
            end
            ST_DATA: begin
                idle_run = !accept_c;
                if (pk_done_c) begin
                    state_d = ST_WRITE;
                    waddr_d = BASE_ADDR + (idx_q << 2);
                    wdata_d = pk_word_c;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q == len_q - 32'd1) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (accept_c) state_d = (rx_data_i == pk_csum) ? ST_DONE : ST_ERR;
                else          idle_run = 1'b1;
            end
            ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d   = ST_LEN;
                    len_cnt_d = '0;
                    len_d     = '0;
                    idx_d     = '0;
                end
            end
            default: state_d = ST_ERR;
        endcase

        idle_d = idle_run ? idle_q + 32'd1 : 32'd0;
        if (TIMEOUT != 0 && idle_run && idle_d == 32'(TIMEOUT)) state_d = ST_ERR;

        rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        mem_we_d   = (state_d == ST_WRITE);
        core_rst_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        busy_d     = (state_d == ST_LEN && len_cnt_d != '0) || (state_d == ST_DATA)
                  || (state_d == ST_WRITE) || (state_d == ST_CSUM);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_LEN;
            len_cnt_q   <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            idle_q      <= '0;
            rx_ready_o  <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= BASE_ADDR;
            mem_wdata_o <= '0;
            core_rst_o  <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_cnt_q   <= len_cnt_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            rx_ready_o  <= rx_ready_d;
            mem_we_o    <= mem_we_d;
            mem_waddr_o <= waddr_d;
            mem_wdata_o <= wdata_d;
            core_rst_o  <= core_rst_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: framing, checksum, length limits, flow control, timeout, reset.
module tb_instr_mem_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        start_i = 1'b0;
    logic        rx_ready_o, mem_we_o, core_rst_o, busy_o, done_o, err_o;
    logic [31:0] mem_waddr_o, mem_wdata_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int cyc = 0;
    int last_we = -100;
    int gap_err = 0;

    // {rx_ready, we, core_rst, busy, done, err}
    localparam logic [5:0] V_IDLE = 6'b101000;
    localparam logic [5:0] V_DONE = 6'b000010;
    localparam logic [5:0] V_ERR  = 6'b001001;
    localparam logic [5:0] V_BUSY = 6'b101100;

    instr_mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(16384), .TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .start_i     (start_i),
        .mem_waddr_o (mem_waddr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .core_rst_o  (core_rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        cyc++;
        if (mem_we_o) begin
            wq_addr.push_back(mem_waddr_o);
            wq_data.push_back(mem_wdata_o);
            if (cyc - last_we < 4) gap_err++;
            last_we = cyc;
        end
    end

    function automatic logic [5:0] outv();
        return {rx_ready_o, mem_we_o, core_rst_o, busy_o, done_o, err_o};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        while (!rx_ready_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL send_byte: rx_ready_o stayed 0 for 50 cycles, required 1");
        end
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    // Two-word frame: 0x00000013, 0x00100093; payload XOR = 0x90
    task automatic send_frame2(input logic [7:0] cs);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(cs);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (outv() !== V_IDLE) begin fails++; $display("FAIL reset_flags: got %b, expected %b", outv(), V_IDLE); end
        tests++;
        if ({mem_waddr_o, mem_wdata_o} !== 64'h0) begin
            fails++; $display("FAIL reset_bus: got %h, expected 0", {mem_waddr_o, mem_wdata_o});
        end
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_good_frame();
        wq_addr.delete(); wq_data.delete();
        send_frame2(8'h90);
        tests++;
        if (outv() !== V_DONE) begin fails++; $display("FAIL good_flags: got %b, expected %b", outv(), V_DONE); end
        tests++;
        if (wq_addr.size() != 2) begin
            fails++; $display("FAIL good_nwrites: got %0d, expected 2", wq_addr.size());
        end else if ({wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]} !== 128'h00000000_00000013_00000004_00100093) begin
            fails++; $display("FAIL good_writes: got %h %h %h %h, expected 0 13 4 100093",
                              wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
    endtask

    task automatic test_bad_csum();
        do_start();
        tests++;
        if (outv() !== V_IDLE) begin fails++; $display("FAIL start_from_done: got %b, expected %b", outv(), V_IDLE); end
        wq_addr.delete(); wq_data.delete();
        send_frame2(8'h81);
        tests++;
        if (outv() !== V_ERR) begin fails++; $display("FAIL badcs_flags: got %b, expected %b", outv(), V_ERR); end
        tests++;
        if (wq_addr.size() != 2) begin
            fails++; $display("FAIL badcs_nwrites: got %0d, expected 2", wq_addr.size());
        end else if ({wq_addr[1], wq_data[1]} !== 64'h00000004_00100093) begin
            fails++; $display("FAIL badcs_writes: got %h %h, expected 4 100093", wq_addr[1], wq_data[1]);
        end
    endtask

    task automatic test_len_limits();
        wq_addr.delete(); wq_data.delete();
        do_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        tests++;
        if (outv() !== V_ERR) begin fails++; $display("FAIL len_zero: got %b, expected %b", outv(), V_ERR); end
        do_start();
        send_byte(8'h01); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
        tests++;
        if (outv() !== V_ERR) begin fails++; $display("FAIL len_over: got %b, expected %b", outv(), V_ERR); end
        do_start();
        send_byte(8'h00); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
        tests++;
        if (outv() !== V_BUSY) begin fails++; $display("FAIL len_max: got %b, expected %b", outv(), V_BUSY); end
        repeat (18) @(posedge clk_i);
        #1;
        tests++;
        if (outv() !== V_ERR) begin fails++; $display("FAIL len_max_abort: got %b, expected %b", outv(), V_ERR); end
        tests++;
        if (wq_addr.size() != 0) begin fails++; $display("FAIL len_nowrite: got %0d writes, expected 0", wq_addr.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bb [17];
        int i, ncyc, nlow, nbad;
        logic acc;
        bb = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
               8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h45};
        do_start();
        wq_addr.delete(); wq_data.delete();
        gap_err = 0;
        i = 0; ncyc = 0; nlow = 0; nbad = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = bb[0];
        while (i < 17 && ncyc < 100) begin
            @(negedge clk_i);
            ncyc++;
            acc = rx_ready_o;
            if (!rx_ready_o) nlow++;
            if (rx_ready_o === mem_we_o) nbad++;
            @(posedge clk_i); #1;
            if (acc) begin
                i++;
                if (i < 17) rx_data_i = bb[i];
            end
        end
        rx_valid_i = 1'b0;
        tests++;
        if (ncyc != 20 || nlow != 3 || nbad != 0) begin
            fails++; $display("FAIL b2b_flow: got cycles=%0d ready_low=%0d ready_we_clash=%0d, expected 20 3 0",
                              ncyc, nlow, nbad);
        end
        tests++;
        if (wq_addr.size() != 3) begin
            fails++; $display("FAIL b2b_nwrites: got %0d, expected 3", wq_addr.size());
        end else if ({wq_addr[0], wq_data[0], wq_addr[1], wq_data[1], wq_addr[2], wq_data[2]}
                     !== 192'h00000000_11223344_00000004_AABBCCDD_00000008_00000001) begin
            fails++; $display("FAIL b2b_writes: got %h/%h %h/%h %h/%h", wq_addr[0], wq_data[0],
                              wq_addr[1], wq_data[1], wq_addr[2], wq_data[2]);
        end
        tests++;
        if (gap_err != 0) begin fails++; $display("FAIL b2b_we_gap: got %0d close writes, expected 0", gap_err); end
        tests++;
        if (outv() !== V_DONE) begin fails++; $display("FAIL b2b_done: got %b, expected %b", outv(), V_DONE); end
    endtask

    task automatic test_timeout();
        do_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        repeat (15) @(posedge clk_i);
        #1;
        tests++;
        if (err_o !== 1'b0) begin fails++; $display("FAIL to_early: err_o got %b, expected 0", err_o); end
        @(posedge clk_i); #1;
        tests++;
        if (outv() !== V_ERR) begin fails++; $display("FAIL to_expire: got %b, expected %b", outv(), V_ERR); end
        do_start();
        tests++;
        if (outv() !== V_IDLE) begin fails++; $display("FAIL to_restart: got %b, expected %b", outv(), V_IDLE); end
        wq_addr.delete(); wq_data.delete();
        send_frame2(8'h90);
        tests++;
        if (outv() !== V_DONE || wq_addr.size() != 2) begin
            fails++; $display("FAIL to_reload: got %b with %0d writes, expected %b with 2", outv(), wq_addr.size(), V_DONE);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        rst_ni = 1'b0;
        #2;
        tests++;
        if (outv() !== V_IDLE || {mem_waddr_o, mem_wdata_o} !== 64'h0) begin
            fails++; $display("FAIL rst_async: got %b %h %h, expected %b 0 0", outv(), mem_waddr_o, mem_wdata_o, V_IDLE);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        wq_addr.delete(); wq_data.delete();
        send_frame2(8'h90);
        tests++;
        if (wq_addr.size() != 2) begin
            fails++; $display("FAIL rst_reload_n: got %0d, expected 2", wq_addr.size());
        end else if ({wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]} !== 128'h00000000_00000013_00000004_00100093) begin
            fails++; $display("FAIL rst_reload_w: got %h %h %h %h", wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
        tests++;
        if (outv() !== V_DONE) begin fails++; $display("FAIL rst_reload_done: got %b, expected %b", outv(), V_DONE); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len_limits();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
